// File: rtl/stack_pointer_unit_pkg.sv
// Shared definitions for the stack pointer unit: control-bus bit indices, SP
// reset value, SP I/O addresses and the memory-port FSM encoding.
package stack_pointer_unit_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 16;

  // Control-bus bit indices from the signal generation stage.
  // CONTROL_STACK_ACCESS marks a MEM-stage access whose address comes from SP.
  localparam int CONTROL_MEM_READ      = 0;
  localparam int CONTROL_MEM_WRITE     = 1;
  localparam int CONTROL_STACK_PREINC  = 2;
  localparam int CONTROL_STACK_POSTDEC = 3;
  localparam int CONTROL_STACK_ACCESS  = 4;
  localparam int SIGNAL_COUNT          = 5;

  localparam logic [ADDR_WIDTH-1:0] STACK_INIT  = 16'h00DF;
  localparam logic [5:0]            IO_SPL_ADDR = 6'h3D;
  localparam logic [5:0]            IO_SPH_ADDR = 6'h3E;

  typedef enum logic [1:0] {
    SPU_IDLE = 2'd0,
    SPU_REQ  = 2'd1,
    SPU_DONE = 2'd2
  } spu_state_e;

endpackage

// File: rtl/stack_pointer_unit_if.sv
// Data-memory port of the stack pointer unit.
// mem_req is valid, mem_ready is ready; a transfer completes in a cycle where both
// are high. While mem_req is high and mem_ready low, every mem_* output is held stable.
interface stack_pointer_unit_if;
  import stack_pointer_unit_pkg::*;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ready;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );

endinterface

// File: rtl/stack_pointer_unit_sp_register.sv
// Stack pointer flop with byte-wise I/O load and modulo inc/dec.
// Priority: reset > matching I/O write > PREINC/POSTDEC (both together cancel).
module sp_register
  import stack_pointer_unit_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  preinc_i,
  input  logic                  postdec_i,
  input  logic                  io_we_i,
  input  logic [5:0]            io_addr_i,
  input  logic [DATA_WIDTH-1:0] io_wdata_i,
  output logic [ADDR_WIDTH-1:0] sp_d_o,
  output logic [ADDR_WIDTH-1:0] sp_o
);

  logic [ADDR_WIDTH-1:0] sp_q;
  logic [ADDR_WIDTH-1:0] sp_d;

  always_comb begin
    sp_d = sp_q;
    if (io_we_i && io_addr_i == IO_SPL_ADDR) begin
      sp_d[7:0] = io_wdata_i;
    end else if (io_we_i && io_addr_i == IO_SPH_ADDR) begin
      sp_d[15:8] = io_wdata_i;
    end else if (preinc_i && !postdec_i) begin
      sp_d = sp_q + ADDR_WIDTH'(1);
    end else if (postdec_i && !preinc_i) begin
      sp_d = sp_q - ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q <= STACK_INIT;
    end else begin
      sp_q <= sp_d;
    end
  end

  assign sp_d_o = sp_d;
  assign sp_o   = sp_q;

endmodule

// File: rtl/stack_pointer_unit.sv
// Consumer of the control bus: owns SP and the data-memory port, and stalls the
// pipeline while a memory request is outstanding.
module stack_pointer_unit
  import stack_pointer_unit_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SIGNAL_COUNT-1:0] signals,
  input  logic [ADDR_WIDTH-1:0]   mem_addr_in,
  input  logic [DATA_WIDTH-1:0]   wdata_in,
  input  logic                    io_we,
  input  logic [5:0]              io_addr,
  input  logic [DATA_WIDTH-1:0]   io_wdata,
  stack_pointer_unit_if.master    mem,
  output logic [DATA_WIDTH-1:0]   rdata_out,
  output logic [ADDR_WIDTH-1:0]   sp,
  output logic                    stall,
  output spu_state_e              dbg_state_o
);

  spu_state_e            state_q;
  logic                  req_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  stall_q;

  logic                  mem_rd;
  logic                  mem_wr;
  logic                  mem_strobe;
  logic [ADDR_WIDTH-1:0] sp_next;
  logic [ADDR_WIDTH-1:0] req_addr_d;

  assign mem_rd     = signals[CONTROL_MEM_READ];
  assign mem_wr     = signals[CONTROL_MEM_WRITE];
  assign mem_strobe = mem_rd | mem_wr;

  sp_register u_sp_register (
    .clk        (clk),
    .reset      (reset),
    .preinc_i   (signals[CONTROL_STACK_PREINC]),
    .postdec_i  (signals[CONTROL_STACK_POSTDEC]),
    .io_we_i    (io_we),
    .io_addr_i  (io_addr),
    .io_wdata_i (io_wdata),
    .sp_d_o     (sp_next),
    .sp_o       (sp)
  );

  // A push writes at the old SP; a pop reads at the incremented SP, which is
  // sp_next if the PREINC lands in this same cycle and sp otherwise.
  always_comb begin
    req_addr_d = mem_addr_in;
    if (signals[CONTROL_STACK_ACCESS]) begin
      req_addr_d = mem_wr ? sp : sp_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SPU_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      stall_q <= 1'b0;
    end else begin
      case (state_q)
        SPU_IDLE: begin
          if (mem_strobe) begin
            req_q   <= 1'b1;
            stall_q <= 1'b1;
            we_q    <= mem_wr;
            addr_q  <= req_addr_d;
            wdata_q <= wdata_in;
            state_q <= SPU_REQ;
          end
        end
        SPU_REQ: begin
          if (mem.mem_ready) begin
            if (!we_q) begin
              rdata_q <= mem.mem_rdata;
            end
            req_q   <= 1'b0;
            stall_q <= 1'b0;
            state_q <= SPU_DONE;
          end
        end
        SPU_DONE: begin
          state_q <= SPU_IDLE;
        end
        default: begin
          state_q <= SPU_IDLE;
        end
      endcase
    end
  end

  // The stage must already freeze in the cycle the strobe is accepted.
  assign stall = stall_q | (state_q == SPU_IDLE && mem_strobe && !reset);

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign rdata_out     = rdata_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_stack_pointer_unit.sv
// Self-checking bench for stack_pointer_unit: push/pop, SP wrap, I/O SP writes,
// plain loads/stores with random latency, and reset during an open request.
module tb_stack_pointer_unit;
  import stack_pointer_unit_pkg::*;

  localparam logic [SIGNAL_COUNT-1:0] S_NONE = '0;
  localparam logic [SIGNAL_COUNT-1:0] S_INC  = SIGNAL_COUNT'(1) << CONTROL_STACK_PREINC;
  localparam logic [SIGNAL_COUNT-1:0] S_DEC  = SIGNAL_COUNT'(1) << CONTROL_STACK_POSTDEC;
  localparam logic [SIGNAL_COUNT-1:0] S_RD   = SIGNAL_COUNT'(1) << CONTROL_MEM_READ;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [SIGNAL_COUNT-1:0] signals;
  logic [ADDR_WIDTH-1:0]   mem_addr_in;
  logic [DATA_WIDTH-1:0]   wdata_in;
  logic                    io_we;
  logic [5:0]              io_addr;
  logic [DATA_WIDTH-1:0]   io_wdata;
  logic [DATA_WIDTH-1:0]   rdata_out;
  logic [ADDR_WIDTH-1:0]   sp;
  logic                    stall;
  spu_state_e              dbg_state;

  stack_pointer_unit_if mif ();

  stack_pointer_unit dut (
    .clk         (clk),
    .reset       (reset),
    .signals     (signals),
    .mem_addr_in (mem_addr_in),
    .wdata_in    (wdata_in),
    .io_we       (io_we),
    .io_addr     (io_addr),
    .io_wdata    (io_wdata),
    .mem         (mif),
    .rdata_out   (rdata_out),
    .sp          (sp),
    .stall       (stall),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];   // {we, addr, wdata-or-0} per request
  logic [31:0] rd_q[$];    // expected rdata_out per read
  logic [7:0]  mem_model [logic [15:0]];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [SIGNAL_COUNT-1:0] sig, input logic iw,
                       input logic [5:0] ia, input logic [7:0] idat);
    signals  = sig;
    io_we    = iw;
    io_addr  = ia;
    io_wdata = idat;
    step();
    signals  = S_NONE;
    io_we    = 1'b0;
  endtask

  // One memory transaction; lat = REQ cycles until mem_ready is given.
  task automatic mem_txn(input logic wr, input logic stack, input logic [15:0] addr_in,
                         input logic [7:0] wd, input int lat, input logic hold,
                         input logic [15:0] exp_addr, input string tag);
    logic [SIGNAL_COUNT-1:0] sig;
    logic [31:0] exp_req;
    logic [7:0]  rdv;
    int stall_cnt;
    bit got;
    bit done;
    sig = S_NONE;
    sig[wr ? CONTROL_MEM_WRITE : CONTROL_MEM_READ] = 1'b1;
    sig[CONTROL_STACK_ACCESS] = stack;
    rdv = 8'h00;
    exp_q.push_back(32'({wr, exp_addr, wr ? wd : 8'h00}));
    if (wr) begin
      mem_model[exp_addr] = wd;
    end else begin
      rdv = mem_model.exists(exp_addr) ? mem_model[exp_addr] : 8'h00;
      rd_q.push_back(32'(rdv));
    end
    signals     = sig;
    mem_addr_in = addr_in;
    wdata_in    = wd;
    stall_cnt   = 0;
    got         = 0;
    done        = 0;
    exp_req     = 32'h0;
    @(negedge clk);
    if (stall) stall_cnt++;
    step();
    if (!hold) signals = S_NONE;
    for (int c = 0; c < 32; c++) begin
      if (!mif.mem_req) begin
        done = 1;
        break;
      end
      if (!got) begin
        exp_req = exp_q.pop_front();
        got = 1;
      end
      check({tag, "_req"}, 32'({mif.mem_we, mif.mem_addr, mif.mem_we ? mif.mem_wdata : 8'h00}), exp_req);
      mif.mem_ready = (c == lat - 1);
      mif.mem_rdata = (c == lat - 1) ? rdv : 8'($urandom);
      @(negedge clk);
      if (stall) stall_cnt++;
      step();
      mif.mem_ready = 1'b0;
      mif.mem_rdata = 8'($urandom);
    end
    check({tag, "_done_in_budget"}, 32'(done), 32'd1);
    check({tag, "_req_seen"}, 32'(got), 32'd1);
    if (!got) void'(exp_q.pop_front());
    @(negedge clk);
    check({tag, "_stall_done"}, 32'(stall), 32'd0);
    if (!wr) check({tag, "_rdata"}, 32'(rdata_out), rd_q.pop_front());
    check({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(lat + 1));
    step();
    signals = S_NONE;
    check({tag, "_idle_no_req"}, 32'(mif.mem_req), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] ra;
    logic [7:0]  rd;
    reset = 1'b1;
    signals = S_NONE;
    mem_addr_in = '0;
    wdata_in = '0;
    io_we = 1'b0;
    io_addr = '0;
    io_wdata = '0;
    mif.mem_ready = 1'b0;
    mif.mem_rdata = '0;
    repeat (2) step();
    check("rst_sp", 32'(sp), 32'h00DF);
    check("rst_mem_req", 32'(mif.mem_req), 32'd0);
    check("rst_mem_we", 32'(mif.mem_we), 32'd0);
    check("rst_mem_addr", 32'(mif.mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mif.mem_wdata), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_rdata", 32'(rdata_out), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(SPU_IDLE));
    reset = 1'b0;
    step();

    mem_txn(1'b1, 1'b1, 16'h1111, 8'hA5, 1, 1'b0, 16'h00DF, "push");
    pulse(S_DEC, 1'b0, 6'h00, 8'h00);
    check("push_sp", 32'(sp), 32'h00DE);
    pulse(S_INC, 1'b0, 6'h00, 8'h00);
    check("pop_sp_ex", 32'(sp), 32'h00DF);
    mem_txn(1'b0, 1'b1, 16'h2222, 8'h00, 3, 1'b0, 16'h00DF, "pop");

    pulse(S_NONE, 1'b1, IO_SPH_ADDR, 8'h00);
    pulse(S_NONE, 1'b1, IO_SPL_ADDR, 8'h00);
    check("io_sp_zero", 32'(sp), 32'h0000);
    mem_txn(1'b1, 1'b1, 16'h3333, 8'h5A, 2, 1'b0, 16'h0000, "push_wrap");
    pulse(S_DEC, 1'b0, 6'h00, 8'h00);
    check("dec_wrap", 32'(sp), 32'hFFFF);
    pulse(S_INC, 1'b0, 6'h00, 8'h00);
    check("inc_wrap", 32'(sp), 32'h0000);
    mem_txn(1'b0, 1'b1, 16'h4444, 8'h00, 1, 1'b1, 16'h0000, "pop_wrap");

    pulse(S_DEC, 1'b1, IO_SPL_ADDR, 8'h77);
    check("io_beats_dec", 32'(sp), 32'h0077);
    pulse(S_NONE, 1'b1, 6'h3F, 8'h12);
    check("io_other_addr", 32'(sp), 32'h0077);
    pulse(S_INC | S_DEC, 1'b0, 6'h00, 8'h00);
    check("inc_dec_cancel", 32'(sp), 32'h0077);
    pulse(S_INC, 1'b1, IO_SPH_ADDR, 8'hAB);
    check("io_sph_beats_inc", 32'(sp), 32'hAB77);

    for (int i = 0; i < 4; i++) begin
      ra = 16'($urandom);
      rd = 8'($urandom);
      mem_txn(1'b1, 1'b0, ra, rd, $urandom_range(1, 4), 1'($urandom_range(0, 1)), ra, "st");
      mem_txn(1'b0, 1'b0, ra, 8'h00, $urandom_range(1, 4), 1'($urandom_range(0, 1)), ra, "ld");
    end
    check("sp_kept_by_ldst", 32'(sp), 32'hAB77);

    signals = S_RD;
    mem_addr_in = 16'h0042;
    step();
    signals = S_NONE;
    check("rstreq_req", 32'(mif.mem_req), 32'd1);
    check("rstreq_addr", 32'(mif.mem_addr), 32'h0042);
    step();
    reset = 1'b1;
    mif.mem_rdata = 8'hEE;
    step();
    check("rstreq_mem_req", 32'(mif.mem_req), 32'd0);
    check("rstreq_stall", 32'(stall), 32'd0);
    check("rstreq_sp", 32'(sp), 32'h00DF);
    check("rstreq_rdata", 32'(rdata_out), 32'd0);
    check("rstreq_state", 32'(dbg_state), 32'(SPU_IDLE));
    reset = 1'b0;
    mif.mem_ready = 1'b1;
    step();
    check("rstreq_idle_after", 32'(mif.mem_req), 32'd0);
    check("rstreq_rdata_after", 32'(rdata_out), 32'd0);
    mif.mem_ready = 1'b0;

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("rd_q_empty", 32'(rd_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
